// File: rtl/hmc_sched_pkg.sv
// Shared types and helpers for the HMC response flit scheduler.
// Holds the FSM state encoding, the legal-length bound and the flit-keep test.
package hmc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  localparam logic [3:0] LNG_MAX = 4'd9;

  // Flit f of a beat survives only while it lies below the valid-flit count n.
  function automatic logic flit_mask_bit(input logic [3:0] n, input int f);
    return (5'(f) < {1'b0, n});
  endfunction

  function automatic logic lng_legal(input logic [3:0] lng);
    return (lng != 4'd0) && (lng <= LNG_MAX);
  endfunction

endpackage

// File: rtl/hmc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer;
// the pointer moves past the granted requester on each advance strobe.
module hmc_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] gidx_s;
  logic [IW-1:0] nxt_ptr_s;
  logic          found_s;

  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % NUM_REQ);
  endfunction

  // Rotating-priority search, first hit at or after the pointer wins.
  always_comb begin
    grant   = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req[rot_idx(ptr_r, k)]) begin
        grant[rot_idx(ptr_r, k)] = 1'b1;
        gidx_s                   = rot_idx(ptr_r, k);
        found_s                  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    nxt_ptr_s = (int'(gidx_s) + 1 >= NUM_REQ) ? '0 : gidx_s + IW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (res) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= nxt_ptr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/hmc_rsp_flit_scheduler.sv
// Merges packet beats from several response requesters onto one registered
// flit-word stream, granting whole packets round-robin and masking tail flits.
module hmc_rsp_flit_scheduler
  import hmc_sched_pkg::*;
#(
  parameter int FPW       = 4,
  parameter int FLIT_SIZE = 128,
  parameter int DWIDTH    = 512,
  parameter int NUM_REQ   = 2
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]      req_lng,
  output logic [DWIDTH-1:0]         phy_data_rx_phy2link,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      lng_err
);

  localparam logic [3:0] FPW_C = 4'(FPW);

  sched_state_e        state_r, state_s;
  logic [NUM_REQ-1:0]  owner_r, owner_s;
  logic                first_r, first_s;
  logic [3:0]          rem_r, rem_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic                adv_s;
  logic                can_load_s;
  logic                own_valid_s;
  logic                accept_s;
  logic [DWIDTH-1:0]   sel_data_s;
  logic [3:0]          sel_lng_s;
  logic [3:0]          cur_rem_s;
  logic [3:0]          take_s;
  logic                illegal_s;
  logic                last_s;
  logic [DWIDTH-1:0]   word_s;
  logic [DWIDTH-1:0]   data_r;
  logic                valid_r, sop_r, eop_r, err_r;

  hmc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .res     (res),
    .req     (req_valid),
    .advance (adv_s),
    .grant   (grant_s)
  );

  assign can_load_s  = ~valid_r | out_ready;
  assign own_valid_s = |(owner_r & req_valid);
  assign req_ready   = (state_r == ST_SEND && !res && can_load_s) ? owner_r : '0;
  assign accept_s    = |(req_ready & req_valid);

  // One-hot owner mux of beat data and length field.
  always_comb begin
    sel_data_s = '0;
    sel_lng_s  = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = sel_data_s | (req_data[i*DWIDTH +: DWIDTH] & {DWIDTH{owner_r[i]}});
      sel_lng_s  = sel_lng_s  | (req_lng[i*4 +: 4] & {4{owner_r[i]}});
    end
  end

  // Beat accounting: flits carried by this beat and tail-flit masking.
  always_comb begin
    cur_rem_s = first_r ? sel_lng_s : rem_r;
    take_s    = (cur_rem_s < FPW_C) ? cur_rem_s : FPW_C;
    illegal_s = first_r & ~lng_legal(sel_lng_s);
    last_s    = illegal_s | (cur_rem_s <= FPW_C);
    word_s    = '0;
    for (int f = 0; f < FPW; f++) begin
      word_s[f*FLIT_SIZE +: FLIT_SIZE] = sel_data_s[f*FLIT_SIZE +: FLIT_SIZE]
                                         & {FLIT_SIZE{flit_mask_bit(take_s, f)}};
    end
  end

  // Next-state logic; the successor is picked in the cycle of the last beat.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    first_s = first_r;
    rem_s   = rem_r;
    adv_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_s = ST_SEND;
          owner_s = grant_s;
          first_s = 1'b1;
          adv_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (accept_s && last_s) begin
          owner_s = grant_s;
          first_s = 1'b1;
          rem_s   = 4'd0;
          adv_s   = 1'b1;
          state_s = ST_SEND;
        end else if (accept_s) begin
          first_s = 1'b0;
          rem_s   = cur_rem_s - take_s;
        end else if (first_r && !own_valid_s) begin
          // A successor with nothing to send gives the grant back.
          owner_s = '0;
          first_s = 1'b0;
          state_s = (valid_r && !out_ready) ? ST_DRAIN : ST_IDLE;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DRAIN: begin
        if (can_load_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        owner_s = '0;
        first_s = 1'b0;
        rem_s   = 4'd0;
      end
    endcase
  end

  // FSM and packet-tracking registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= ST_IDLE;
      owner_r <= '0;
      first_r <= 1'b0;
      rem_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      first_r <= first_s;
      rem_r   <= rem_s;
    end
  end

  // Output word register; holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (res) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= accept_s & illegal_s;
      if (can_load_s) begin
        valid_r <= accept_s & ~illegal_s;
        sop_r   <= accept_s & ~illegal_s & first_r;
        eop_r   <= accept_s & ~illegal_s & last_s;
        data_r  <= (accept_s && !illegal_s) ? word_s : data_r;
      end else begin
        valid_r <= valid_r;
        sop_r   <= sop_r;
        eop_r   <= eop_r;
        data_r  <= data_r;
      end
    end
  end

  assign phy_data_rx_phy2link = data_r;
  assign out_valid            = valid_r;
  assign out_sop              = sop_r;
  assign out_eop              = eop_r;
  assign lng_err              = err_r;

endmodule

// File: doc/hmc_rsp_flit_scheduler.md
HMC_RSP_FLIT_SCHEDULER -- requirements
Module: hmc_rsp_flit_scheduler

Interface
REQ-001 Parameter FPW, default 4: flits per output word.
REQ-002 Parameter FLIT_SIZE, default 128: bits per flit.
REQ-003 Parameter DWIDTH, default 512: output word width; SHALL equal FPW*FLIT_SIZE.
REQ-004 Parameter NUM_REQ, default 2: number of response requesters.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port res, input, 1: reset; synchronous, active-high.
REQ-007 Port req_valid, input, NUM_REQ: requester i presents one beat.
REQ-008 Port req_ready, output, NUM_REQ: beat of requester i accepted this cycle.
REQ-009 Port req_data, input, NUM_REQ*DWIDTH: beats; requester i occupies bits [i*DWIDTH +: DWIDTH]; flit 0 is the LSBs.
REQ-010 Port req_lng, input, NUM_REQ*4: packet length in flits; sampled only on a packet's first beat.
REQ-011 Port phy_data_rx_phy2link, output, DWIDTH: scheduled word.
REQ-012 Port out_valid, output, 1: word valid.
REQ-013 Port out_ready, input, 1: sink accepts word.
REQ-014 Port out_sop / out_eop, output, 1 each: first / last word of packet.
REQ-015 Port lng_err, output, 1: one-cycle pulse on illegal LNG.

Function
REQ-016 FSM states: IDLE, SEND, DRAIN; IDLE->SEND on grant, SEND->DRAIN when last beat accepted while output stalled, SEND/DRAIN->IDLE when last word handed to output register.
REQ-017 Arbitration SHALL be round-robin at packet boundaries only: pointer starts at 0, moves to granted index+1 (mod NUM_REQ) after each completed packet.
REQ-018 Once granted, requester keeps grant until its packet's flits are all accepted; other req_valid ignored.
REQ-019 Remaining-flit counter (4 bits) loaded with LNG on first beat, decremented by min(remaining, FPW) per accepted beat.
REQ-020 Beats per packet SHALL be ceil(LNG/FPW); LNG=9, FPW=4 -> 3 beats.
REQ-021 On the last beat, flits at index >= remaining SHALL be forced to zero.
REQ-022 Words SHALL never mix two packets.
REQ-023 Legal LNG 1..9; LNG 0 or >9: consume one beat, pulse lng_err, emit nothing, advance pointer.
REQ-024 Output registered: accepted beat appears on phy_data_rx_phy2link one cycle later.
REQ-025 req_ready(i) = grant(i) AND (NOT out_valid OR out_ready); at most one bit set.
REQ-026 out_valid held, data/sop/eop stable, while out_ready low.
REQ-027 With out_ready held high, back-to-back packets SHALL have no idle cycle (arbitrate in cycle of last beat).
REQ-028 NUM_REQ=1 SHALL degenerate to pass-through with masking.

Reset
REQ-029 While res high: out_valid, out_sop, out_eop, lng_err, req_ready = 0; phy_data_rx_phy2link = 0; state IDLE; counter 0; pointer 0.
REQ-030 Reset mid-packet SHALL discard the partial packet; first cycle after reset is arbitration-only.

Structure
REQ-031 Shared package hmc_sched_pkg: state enum, LNG_MAX=9, flit-mask function.
REQ-032 One sub-module hmc_rr_arbiter (NUM_REQ request vector, advance strobe, one-hot grant).

Verification
REQ-033 LNG=1 from req0, out_ready=1 -> one word, sop=eop=1, flits 1..3 zero, 1-cycle latency.
REQ-034 LNG=9 from req1 -> 3 words, sop on 1st, eop on 3rd, 3rd word flits 1..3 zero.
REQ-035 Both valid continuously, LNG=2 each -> grants alternate 0,1,0,1 with no gap cycles.
REQ-036 out_ready low 5 cycles mid LNG=6 packet -> data stable, req_ready=0, no flit lost.
REQ-037 LNG=0 on req0 -> lng_err pulse, no out_valid, req1 granted next.
REQ-038 res asserted after 1st beat of LNG=8 -> all outputs 0 next cycle, new packet then starts with sop.
